// File: rtl/timing_pkg.sv
// Shared defaults and arithmetic helpers for the symbol-timing loop.
//   WP_DEF / WE_DEF : default loop-word and TED error widths
//   lock_state_t    : lock detector states
//   step_nom        : rounded nominal NCO step, round(2^wp / osf)
//   sat_add         : signed add clamped to +/-lim
//   abs_sat         : |e| of a we-bit signed value, most-negative maps to max positive
package timing_pkg;

  localparam int unsigned WP_DEF = 32;
  localparam int unsigned WE_DEF = 18;

  typedef enum logic {
    LK_UNLOCKED,
    LK_LOCKED
  } lock_state_t;

  function automatic logic [63:0] step_nom(input int unsigned osf, input int unsigned wp);
    logic [63:0] full;
    full = 64'd1 << wp;
    return (full + 64'(osf / 2)) / 64'(osf);
  endfunction

  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input logic signed [63:0] lim);
    logic signed [63:0] s;
    s = a + b;
    if (s > lim)       return lim;
    else if (s < -lim) return -lim;
    else               return s;
  endfunction

  function automatic logic [63:0] abs_sat(input logic signed [63:0] e, input int unsigned we);
    logic signed [63:0] most_neg;
    most_neg = -(64'sd1 <<< (we - 1));
    if (e == most_neg) return (64'd1 << (we - 1)) - 64'd1;
    else if (e < 0)    return 64'(-e);
    else               return 64'(e);
  endfunction

endpackage

// File: rtl/pi_loop_filter.sv
// Proportional-integral loop filter for the timing loop.
//   clk, reset_n : clock, synchronous active-low reset
//   loop_en      : 0 clears integrator and output on the next clock
//   e_valid      : qualifies e
//   e            : signed TED error, WE bits
//   v            : registered signed step correction, clamped to +/-V_MAX
module pi_loop_filter
  import timing_pkg::*;
#(
  parameter int unsigned   WE        = WE_DEF,
  parameter int unsigned   WP        = WP_DEF,
  parameter int unsigned   ERR_SCALE = 12,
  parameter int unsigned   KP_SH     = 2,
  parameter int unsigned   KI_SH     = 8,
  parameter logic [WP-1:0] V_MAX     = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 loop_en,
  input  logic                 e_valid,
  input  logic signed [WE-1:0] e,
  output logic signed [WP-1:0] v
);

  localparam logic signed [63:0] LIM = $signed(64'(V_MAX));

  logic signed [WP-1:0] e_ext;
  logic signed [WP-1:0] prop;
  logic signed [WP-1:0] integ_inc;
  logic signed [WP-1:0] integ;
  logic signed [WP-1:0] integ_next;
  logic signed [WP-1:0] v_next;

  always_comb begin
    e_ext      = {{(WP-WE){e[WE-1]}}, e} <<< ERR_SCALE;
    prop       = e_ext >>> KP_SH;
    integ_inc  = e_ext >>> KI_SH;
    // Both sums run at 64 bits so the clamp sees the true value before truncation.
    integ_next = WP'(sat_add(64'(integ), 64'(integ_inc), LIM));
    v_next     = WP'(sat_add(64'(prop), 64'(integ_next), LIM));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      integ <= '0;
      v     <= '0;
    end else if (!loop_en) begin
      integ <= '0;
      v     <= '0;
    end else if (e_valid) begin
      integ <= integ_next;
      v     <= v_next;
    end
  end

endmodule

// File: rtl/timing_loop_nco.sv
// Symbol-timing loop stage: PI filter, phase-accumulator NCO with symbol
// strobe and fractional offset, and error-magnitude lock detector.
//   clk, reset_n : clock, synchronous active-low reset
//   iq_val_i     : sample enable, advances the NCO
//   e_i, e_valid_i : signed TED error and qualifier
//   loop_en_i    : 0 opens the loop (NCO runs at the nominal step)
//   sym_valid_o  : one-cycle symbol strobe
//   mu_o         : fractional timing offset, updated with the strobe
//   v_o          : signed loop-filter output
//   lock_o       : timing lock
module timing_loop_nco
  import timing_pkg::*;
#(
  parameter int unsigned OSF       = 20,
  parameter int unsigned WE        = WE_DEF,
  parameter int unsigned WP        = WP_DEF,
  parameter int unsigned WMU       = 16,
  parameter int unsigned ERR_SCALE = 12,
  parameter int unsigned KP_SH     = 2,
  parameter int unsigned KI_SH     = 8,
  parameter int unsigned LOCK_THR  = 2048,
  parameter int unsigned LOCK_N    = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  iq_val_i,
  input  logic signed [WE-1:0]  e_i,
  input  logic                  e_valid_i,
  input  logic                  loop_en_i,
  output logic                  sym_valid_o,
  output logic [WMU-1:0]        mu_o,
  output logic signed [WP-1:0]  v_o,
  output logic                  lock_o
);

  localparam logic [WP-1:0] STEP_NOM = WP'(step_nom(OSF, WP));
  localparam logic [WP-1:0] V_MAX    = STEP_NOM >> 3;
  localparam int unsigned   WO       = $clog2(OSF + 1);
  localparam int unsigned   WC       = $clog2(LOCK_N + 1);

  // Loop filter
  pi_loop_filter #(
    .WE        (WE),
    .WP        (WP),
    .ERR_SCALE (ERR_SCALE),
    .KP_SH     (KP_SH),
    .KI_SH     (KI_SH),
    .V_MAX     (V_MAX)
  ) u_filter (
    .clk     (clk),
    .reset_n (reset_n),
    .loop_en (loop_en_i),
    .e_valid (e_valid_i),
    .e       (e_i),
    .v       (v_o)
  );

  // NCO: uses the registered v, so a coincident error only affects later samples
  logic [WP-1:0]     phase;
  logic [WP-1:0]     step;
  logic [WP:0]       sum;
  logic [WP+WO-1:0]  prod;
  logic [WO+WMU-1:0] prod_hi;
  logic [WMU-1:0]    mu_next;

  always_comb begin
    step    = STEP_NOM + $unsigned(v_o);
    sum     = {1'b0, phase} + {1'b0, step};
    prod    = sum[WP-1:0] * (WP+WO)'(OSF);
    prod_hi = (WO+WMU)'(prod >> (WP - WMU));
    // Any bit above 2^WP means the product saturates to all ones.
    mu_next = (prod_hi[WO+WMU-1:WMU] != '0) ? '1 : prod_hi[WMU-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      phase       <= '0;
      sym_valid_o <= 1'b0;
      mu_o        <= '0;
    end else begin
      sym_valid_o <= 1'b0;
      if (iq_val_i) begin
        phase       <= sum[WP-1:0];
        sym_valid_o <= sum[WP];
        if (sum[WP]) mu_o <= mu_next;
      end
    end
  end

  // Lock detector
  lock_state_t   state, state_next;
  logic [WC-1:0] good_cnt;
  logic [WC-1:0] bad_cnt;
  logic          good;
  logic          upd;

  always_comb begin
    good = abs_sat(64'(e_i), WE) < 64'(LOCK_THR);
    upd  = e_valid_i & loop_en_i;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else if (upd) begin
      if (good) begin
        bad_cnt <= '0;
        if (good_cnt != WC'(LOCK_N)) good_cnt <= good_cnt + WC'(1);
      end else begin
        good_cnt <= '0;
        if (bad_cnt != WC'(LOCK_N)) bad_cnt <= bad_cnt + WC'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= LK_UNLOCKED;
    else          state <= state_next;
  end

  // Transition on the error that brings a count to LOCK_N.
  always_comb begin
    state_next = state;
    if (upd) begin
      if (good && good_cnt >= WC'(LOCK_N - 1))
        state_next = LK_LOCKED;
      else if (!good && bad_cnt >= WC'(LOCK_N - 1))
        state_next = LK_UNLOCKED;
    end
  end

  always_comb begin
    lock_o = (state == LK_LOCKED);
  end

endmodule

// File: tb/tb_timing_loop_nco.sv
module tb_timing_loop_nco;

  logic               clk       = 1'b0;
  logic               reset_n   = 1'b0;
  logic               iq_val_i  = 1'b0;
  logic signed [17:0] e_i       = '0;
  logic               e_valid_i = 1'b0;
  logic               loop_en_i = 1'b0;
  logic               sym_valid_o;
  logic [15:0]        mu_o;
  logic signed [31:0] v_o;
  logic               lock_o;

  int checks = 0;
  int errors = 0;
  int strobes, min_gap, max_gap;

  always #5 clk = ~clk;

  timing_loop_nco #(
    .OSF       (20),
    .WE        (18),
    .WP        (32),
    .WMU       (16),
    .ERR_SCALE (12),
    .KP_SH     (2),
    .KI_SH     (8),
    .LOCK_THR  (2048),
    .LOCK_N    (64)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .iq_val_i    (iq_val_i),
    .e_i         (e_i),
    .e_valid_i   (e_valid_i),
    .loop_en_i   (loop_en_i),
    .sym_valid_o (sym_valid_o),
    .mu_o        (mu_o),
    .v_o         (v_o),
    .lock_o      (lock_o)
  );

  task automatic check_eq(input string tag, input logic signed [63:0] got,
                          input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic send_err(input int e, input int n);
    e_i       = 18'(e);
    e_valid_i = 1'b1;
    for (int i = 0; i < n; i++) tick();
    e_valid_i = 1'b0;
  endtask

  task automatic run_iq(input int n, output int s, output int mn, output int mx);
    int gap;
    gap = 0; s = 0; mn = 1 << 30; mx = 0;
    iq_val_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      gap++;
      if (sym_valid_o) begin
        s++;
        if (gap < mn) mn = gap;
        if (gap > mx) mx = gap;
        gap = 0;
      end
    end
    iq_val_i = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    reset_n = 1'b1;
    check_eq("rst_sym",  sym_valid_o, 0);
    check_eq("rst_mu",   mu_o, 0);
    check_eq("rst_v",    v_o, 0);
    check_eq("rst_lock", lock_o, 0);

    // Open loop: errors ignored, exact 20-sample period
    e_i = 18'sd1000; e_valid_i = 1'b1;
    run_iq(20000, strobes, min_gap, max_gap);
    e_valid_i = 1'b0;
    check_eq("open_strobes", strobes, 1000);
    check_eq("open_min_gap", min_gap, 20);
    check_eq("open_max_gap", max_gap, 20);
    check_eq("open_v",       v_o, 0);
    check_eq("open_mu",      mu_o, 1);   // phase 4000 * 20 >> 16

    // PI filter arithmetic
    do_reset();
    loop_en_i = 1'b1;
    send_err(1000, 1);
    check_eq("pi_first",  v_o, 1040000);
    tick(); tick(); tick();
    check_eq("pi_hold",   v_o, 1040000);
    send_err(0, 1);
    check_eq("pi_integ",  v_o, 16000);
    send_err(-1000, 1);
    check_eq("pi_neg",    v_o, -1024000);
    loop_en_i = 1'b0;
    tick();
    check_eq("pi_open_clear", v_o, 0);

    // Saturation and shortened period
    do_reset();
    loop_en_i = 1'b1;
    e_i = 18'sd131071; e_valid_i = 1'b1;
    run_iq(10000, strobes, min_gap, max_gap);
    e_valid_i = 1'b0;
    check_eq("sat_v",       v_o, 26843545);
    check_eq("sat_min_gap", min_gap, 17);
    check_eq("sat_max_gap", max_gap, 18);
    send_err(0, 1);
    check_eq("sat_integ",   v_o, 26843545);
    send_err(-131072, 1);
    check_eq("sat_neg",     v_o, -26843545);

    // Lock detector
    do_reset();
    loop_en_i = 1'b1;
    send_err(100, 63);
    check_eq("lock_63_good", lock_o, 0);
    send_err(100, 1);
    check_eq("lock_64_good", lock_o, 1);
    send_err(5000, 63);
    check_eq("lock_63_bad",  lock_o, 1);
    send_err(5000, 1);
    check_eq("lock_64_bad",  lock_o, 0);
    send_err(-2047, 64);
    check_eq("lock_m2047",   lock_o, 1);
    send_err(-2048, 63);
    check_eq("lock_m2048",   lock_o, 1);
    send_err(-131072, 1);
    check_eq("lock_mostneg", lock_o, 0);
    send_err(100, 64);
    check_eq("lock_relock",  lock_o, 1);
    check_eq("lock_v",       v_o, -830464);

    // Reset mid-lock with v != 0
    iq_val_i = 1'b1;
    do_reset();
    iq_val_i = 1'b0;
    check_eq("mid_rst_sym",  sym_valid_o, 0);
    check_eq("mid_rst_mu",   mu_o, 0);
    check_eq("mid_rst_v",    v_o, 0);
    check_eq("mid_rst_lock", lock_o, 0);
    run_iq(19, strobes, min_gap, max_gap);
    check_eq("mid_rst_19",   strobes, 0);
    run_iq(1, strobes, min_gap, max_gap);
    check_eq("mid_rst_20",   strobes, 1);
    check_eq("mid_rst_mu0",  mu_o, 0);

    // Error coincident with a wrapping sample
    do_reset();
    loop_en_i = 1'b1;
    run_iq(19, strobes, min_gap, max_gap);
    check_eq("coin_pre",   strobes, 0);
    iq_val_i = 1'b1; e_i = 18'sd1000; e_valid_i = 1'b1;
    tick();
    iq_val_i = 1'b0; e_valid_i = 1'b0;
    check_eq("coin_sym",   sym_valid_o, 1);
    check_eq("coin_mu",    mu_o, 0);       // old step: phase 4
    check_eq("coin_v",     v_o, 1040000);
    run_iq(19, strobes, min_gap, max_gap);
    check_eq("coin_next19", strobes, 0);
    run_iq(1, strobes, min_gap, max_gap);
    check_eq("coin_next20", strobes, 1);
    check_eq("coin_mu2",   mu_o, 6347);    // phase 20800008 * 20 >> 16

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
